o_buf_controller: RTL

Linebuffer readout and video timing generator: reads 32-bit words from the output linebuffer BRAM, unpacks them into 8-bit pixels and drives them out with generated vsync/hsync/vde timing. It is the transmit-side counterpart of the input linebuffer controller and uses the same packing, with the first pixel in bits [31:24]. Per-line and per-frame interrupts let the processing system DMA the next line from the DRAM framebuffer into the linebuffer.

---
 rtl/o_buf_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/o_buf_controller.sv
// rtl/o_buf_controller.sv - linebuffer readout and video timing generator
// Optional O_BUF_TEST_PATTERN_EN adds test_mode, which replaces pixels by (h + v)[7:0].
module o_buf_controller #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33
) (
  input  logic                     pclk,
  input  logic                     reset_n,
  input  logic                     enable,
`ifdef O_BUF_TEST_PATTERN_EN
  input  logic                     test_mode,
`endif
  output logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [31:0]              i_data,
  output logic [7:0]               o_data,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     vde,
  output logic                     line_done,
  output logic                     frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [12:0] H_MAX = 13'(H_TOTAL - 1);
  localparam logic [12:0] H_ACT = 13'(H_ACTIVE);
  localparam logic [12:0] H_SS  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SE  = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_MAX = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_ACT = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST = 12'(V_ACTIVE - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state, state_next;
  logic        started, started_next;
  logic [12:0] h_count, h_next;
  logic [11:0] v_count, v_next;
  logic        h_wrap, frame_end, de_next;

  logic        de1, hs1, vs1;
  logic [1:0]  sel1;
  logic [11:0] v1, v2;
  logic [7:0]  pix;
`ifdef O_BUF_TEST_PATTERN_EN
  logic [7:0]  tp1;
  logic        tm1;
`endif

  assign h_wrap    = (h_count == H_MAX);
  assign frame_end = h_wrap && (v_count == V_MAX);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (enable) state_next = ST_RUN;
      ST_RUN:   if (!enable) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (enable) state_next = ST_RUN;
        else if (started && frame_end) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // The first RUN cycle only primes the counters so that (0,0) is held for one more cycle.
  assign started_next = (state != ST_IDLE) && (state_next != ST_IDLE);

  always_comb begin
    h_next = h_count;
    v_next = v_count;
    if (state == ST_IDLE) begin
      h_next = '0;
      v_next = '0;
    end else if (started) begin
      if (h_wrap) begin
        h_next = '0;
        v_next = (v_count == V_MAX) ? '0 : v_count + 12'd1;
      end else begin
        h_next = h_count + 13'd1;
      end
    end
  end

  assign de_next = started_next && (h_next < H_ACT) && (v_next < V_ACT);

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      started <= 1'b0;
      h_count <= '0;
      v_count <= '0;
    end else begin
      state   <= state_next;
      started <= started_next;
      h_count <= h_next;
      v_count <= v_next;
    end
  end

  // addr is computed from the next counter value so it lines up with the counters themselves.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '0;
    end else if (de_next && (h_next[1:0] == 2'b00)) begin
      addr <= ADDRESS_WIDTH'(h_next[12:2]);
    end else if (h_next == '0) begin
      addr <= '0;
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      de1  <= 1'b0;
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      sel1 <= 2'd0;
      v1   <= '0;
`ifdef O_BUF_TEST_PATTERN_EN
      tp1  <= 8'd0;
      tm1  <= 1'b0;
`endif
    end else begin
      de1  <= started && (h_count < H_ACT) && (v_count < V_ACT);
      hs1  <= !(started && (h_count >= H_SS) && (h_count < H_SE));
      vs1  <= !(started && (v_count >= V_SS) && (v_count < V_SE));
      sel1 <= h_count[1:0];
      v1   <= v_count;
`ifdef O_BUF_TEST_PATTERN_EN
      tp1  <= h_count[7:0] + v_count[7:0];
      tm1  <= test_mode;
`endif
    end
  end

  always_comb begin
    pix = i_data[31:24];
    case (sel1)
      2'd1:    pix = i_data[23:16];
      2'd2:    pix = i_data[15:8];
      2'd3:    pix = i_data[7:0];
      default: pix = i_data[31:24];
    endcase
`ifdef O_BUF_TEST_PATTERN_EN
    if (tm1) pix = tp1;
`endif
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      vde        <= 1'b0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      o_data     <= 8'd0;
      v2         <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vde        <= de1;
      hsync      <= hs1;
      vsync      <= vs1;
      o_data     <= de1 ? pix : 8'd0;
      v2         <= v1;
      line_done  <= vde && !de1;
      frame_done <= vde && !de1 && (v2 == V_LAST);
    end
  end

endmodule
